// File: rtl/imem_loader.sv
// Byte-stream program loader: receives length, payload and XOR checksum into a
// small instruction register file and releases the CPU once the image verifies.
module imem_loader #(
    parameter int DEPTH   = 16,
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [3:0] pc,
    output logic [7:0] instruction,
    output logic       cpu_run,
    output logic       load_done,
    output logic       load_error,
    output logic [4:0] prog_len
);

    typedef enum logic [2:0] {IDLE, LEN, DATA, SUM, RUN, ERR} state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state, state_next;
    logic [7:0] mem [DEPTH];
    logic [3:0] wptr;
    logic [4:0] len;
    logic [7:0] csum;

    logic xfer, start, len_ok, last_byte, sum_ok;

    assign in_ready    = (state == LEN) || (state == DATA) || (state == SUM);
    assign xfer        = in_valid && in_ready;
    assign start       = load_start && ((state == IDLE) || (state == RUN) || (state == ERR));
    assign len_ok      = (in_data != 8'd0) && (in_data <= MAX_LEN_B);
    assign last_byte   = ({1'b0, wptr} == (len - 5'd1));
    assign sum_ok      = (in_data == csum);
    assign instruction = mem[pc];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, RUN, ERR: begin
                if (load_start) state_next = LEN;
            end
            LEN: begin
                if (xfer) state_next = len_ok ? DATA : ERR;
            end
            DATA: begin
                if (xfer && last_byte) state_next = SUM;
            end
            SUM: begin
                if (xfer) state_next = sum_ok ? RUN : ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    // The last payload byte does not advance wptr, so a full-depth image never wraps it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
            wptr       <= 4'd0;
            len        <= 5'd0;
            csum       <= 8'h00;
            cpu_run    <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            prog_len   <= 5'd0;
        end else begin
            load_done <= 1'b0;
            cpu_run   <= (state_next == RUN);
            if (start) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
                wptr       <= 4'd0;
                len        <= 5'd0;
                csum       <= 8'h00;
                load_error <= 1'b0;
                prog_len   <= 5'd0;
            end else begin
                if (state_next == ERR) load_error <= 1'b1;
                case (state)
                    LEN: begin
                        if (xfer && len_ok) len <= in_data[4:0];
                    end
                    DATA: begin
                        if (xfer) begin
                            mem[wptr] <= in_data;
                            csum      <= csum ^ in_data;
                            if (!last_byte) wptr <= wptr + 4'd1;
                        end
                    end
                    SUM: begin
                        if (xfer && sum_ok) begin
                            prog_len  <= len;
                            load_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: downloads are pushed to an outcome scoreboard and a
// monitor pops and compares whenever the loader reports success or error.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [3:0] pc = 4'd0;
    logic [7:0] instruction;
    logic       cpu_run;
    logic       load_done;
    logic       load_error;
    logic [4:0] prog_len;

    typedef struct packed {
        logic       ok;
        logic [4:0] len;
    } exp_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    logic [7:0] pay[16];
    int         start_at = -1;
    int         n_checks = 0;
    int         n_fail = 0;
    logic       err_prev = 1'b0;
    logic       done_prev = 1'b0;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(16), .MAX_LEN(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .pc         (pc),
        .instruction(instruction),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .load_error (load_error),
        .prog_len   (prog_len)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Outcome monitor: one scoreboard entry per load_done pulse or load_error rise.
    always @(negedge clk) begin
        if (reset) begin
            if (done_prev) chk("done_pulse_width", load_done, 0);
            if (load_done || (load_error && !err_prev)) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_outcome", sbq.size(), 1);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("sb_done", load_done, mon_e.ok);
                    chk("sb_error", load_error, !mon_e.ok);
                    chk("sb_run", cpu_run, mon_e.ok);
                    chk("sb_len", prog_len, mon_e.len);
                end
            end
        end
        done_prev = load_done;
        err_prev  = load_error;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap, input logic st);
        int t = 0;
        in_valid   = 1'b1;
        in_data    = b;
        load_start = st;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!in_ready) chk("ready_timeout", in_ready, 1);
        tick();
        in_valid   = 1'b0;
        load_start = 1'b0;
        in_data    = 8'h00;
        repeat (gap) tick();
    endtask

    function automatic logic [7:0] model_sum(input int n);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++) s = s ^ pay[i];
        return s;
    endfunction

    task automatic wait_sb();
        int t = 0;
        while (sbq.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        if (sbq.size() != 0) chk("sb_timeout", sbq.size(), 0);
    endtask

    task automatic download(input logic [7:0] lenb, input logic [7:0] sumb, input int gap);
        exp_t e;
        logic ok_len;
        logic ok;
        ok_len = (lenb != 8'd0) && (lenb <= 8'd16);
        ok     = ok_len && (sumb == model_sum(int'(lenb)));
        e.ok   = ok;
        e.len  = ok ? lenb[4:0] : 5'd0;
        sbq.push_back(e);
        do_start();
        send(lenb, gap, 1'b0);
        if (ok_len) begin
            for (int i = 0; i < int'(lenb); i++) send(pay[i], gap, (i == start_at));
            send(sumb, gap, 1'b0);
        end
        wait_sb();
    endtask

    task automatic check_mem(input int n);
        for (int i = 0; i < 16; i++) begin
            pc = 4'(i);
            #1;
            chk($sformatf("mem[%0d]", i), instruction, (i < n) ? pay[i] : 8'h00);
        end
        pc = 4'd0;
    endtask

    task automatic set_nominal();
        pay[0] = 8'h43; pay[1] = 8'h85; pay[2] = 8'hC8; pay[3] = 8'h5A;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_run", cpu_run, 0);
        chk("rst_done", load_done, 0);
        chk("rst_error", load_error, 0);
        chk("rst_len", prog_len, 0);
        chk("rst_instr", instruction, 0);
        reset = 1'b1;
        tick();

        // A byte offered in IDLE is not consumed.
        in_valid = 1'b1;
        in_data  = 8'h04;
        repeat (3) tick();
        chk("idle_ready", in_ready, 0);
        chk("idle_run", cpu_run, 0);
        in_valid = 1'b0;

        // Nominal image; XOR of 43,85,C8,5A is 54.
        set_nominal();
        download(8'h04, 8'h54, 0);
        chk("nom_run", cpu_run, 1);
        chk("nom_len", prog_len, 4);
        pc = 4'd2; #1;
        chk("nom_pc2", instruction, 8'hC8);
        pc = 4'd7; #1;
        chk("nom_pc7", instruction, 8'h00);
        check_mem(4);

        // Same image with three idle cycles between bytes.
        download(8'h04, 8'h54, 3);
        chk("stall_run", cpu_run, 1);
        chk("stall_len", prog_len, 4);
        check_mem(4);

        // 5C is not the XOR of the payload, so the image is rejected.
        download(8'h04, 8'h5C, 0);
        chk("sum5c_error", load_error, 1);
        chk("sum5c_run", cpu_run, 0);

        pay[0] = 8'h11; pay[1] = 8'h22;
        download(8'h02, 8'h00, 0);
        chk("bad_error", load_error, 1);
        chk("bad_run", cpu_run, 0);
        pc = 4'd1; #1;
        chk("err_mem_kept", instruction, 8'h22);
        pc = 4'd0;
        do_start();
        chk("start_clears_err", load_error, 0);

        download(8'h00, 8'h00, 0);
        chk("len0_error", load_error, 1);
        download(8'h11, 8'h00, 0);
        chk("len17_error", load_error, 1);

        for (int i = 0; i < 16; i++) pay[i] = 8'(i);
        download(8'h10, 8'h00, 0);
        chk("full_run", cpu_run, 1);
        chk("full_len", prog_len, 16);
        check_mem(16);

        // Reload from RUN drops the CPU and clears the image.
        do_start();
        chk("reload_run", cpu_run, 0);
        pc = 4'd15; #1;
        chk("reload_mem", instruction, 8'h00);
        pc = 4'd1;

        // Reset in the middle of a download.
        send(8'h04, 0, 1'b0);
        send(8'h43, 0, 1'b0);
        send(8'h85, 0, 1'b0);
        #1;
        chk("partial_written", instruction, 8'h85);
        #2;
        reset = 1'b0;
        #1;
        chk("async_instr", instruction, 8'h00);
        chk("async_ready", in_ready, 0);
        chk("async_run", cpu_run, 0);
        chk("async_done", load_done, 0);
        chk("async_error", load_error, 0);
        chk("async_len", prog_len, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_ready", in_ready, 0);
        pc = 4'd0;

        set_nominal();
        download(8'h04, 8'h54, 0);
        chk("after_rst_run", cpu_run, 1);
        check_mem(4);

        // load_start alongside the second payload byte is ignored.
        start_at = 1;
        download(8'h04, 8'h54, 0);
        start_at = -1;
        chk("ign_start_run", cpu_run, 1);
        chk("ign_start_len", prog_len, 4);
        check_mem(4);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
